// File: rtl/fnd_pkg.sv
// Shared constants for 7-segment display blocks: active-low hex glyphs, blank pattern
// and counter width helpers.
package fnd_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low; entry 15 ('F') first, entry 0 ('0') last.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Width of a counter that runs 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern, with a blank override.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_GLYPHS[nibble];

endmodule

// File: rtl/fnd_scan_mux.sv
// Time-multiplexed common-anode FND driver with frame snapshot, leading-zero blanking and dp.
// Optional per-digit blinking is built when FND_BLINK_EN is defined.
module fnd_scan_mux
  import fnd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [4*DIGITS-1:0]       i_values,
  input  logic [DIGITS-1:0]         i_dp,
  input  logic                      i_blank_lz,
  input  logic [DIGITS-1:0]         i_blink_mask,
  output logic [DIGITS-1:0]         o_an,
  output logic [6:0]                o_seg,
  output logic                      o_dp,
  output logic [$clog2(DIGITS)-1:0] o_digit_pos
);

  localparam int PW = $clog2(DIGITS);
  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(DIGITS - 1);

  logic [TW-1:0]         tick_cnt_reg;
  logic                  tick;
  logic [PW-1:0]         pos_reg;
  logic                  wrap;
  logic [4*DIGITS-1:0]   values_shadow_reg;
  logic [DIGITS-1:0]     dp_shadow_reg;
  logic                  lz_shadow_reg;
  logic [DIGITS:0]       upper_zero;
  logic [DIGITS-1:0]     lz_blank;
  logic [DIGITS-1:0]     an_next;
  logic [3:0]            cur_nibble;
  logic                  cur_blank;
  logic                  cur_dp;
  logic                  blink_off;
  logic [6:0]            seg_next;

  assign tick = (tick_cnt_reg == TICK_LAST);
  assign wrap = tick && (pos_reg == POS_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pos_reg <= '0;
    end else if (wrap) begin
      pos_reg <= '0;
    end else if (tick) begin
      pos_reg <= pos_reg + PW'(1);
    end
  end

  // Inputs are sampled only on the wrap tick so one frame always shows one coherent value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      values_shadow_reg <= '0;
      dp_shadow_reg     <= '0;
      lz_shadow_reg     <= 1'b0;
    end else if (wrap) begin
      values_shadow_reg <= i_values;
      dp_shadow_reg     <= i_dp;
      lz_shadow_reg     <= i_blank_lz;
    end
  end

  // upper_zero[k] is set when nibbles k..DIGITS-1 are all zero; digit 0 is never blanked.
  assign upper_zero[DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign upper_zero[gi] = (values_shadow_reg[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
      if (gi == 0) begin : g_ones
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = lz_shadow_reg && upper_zero[gi];
      end
      assign an_next[gi] = (pos_reg != PW'(gi));
    end
  endgenerate

`ifdef FND_BLINK_EN
  localparam int BW = cnt_width(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0]     blink_cnt_reg;
  logic              phase_reg;
  logic [DIGITS-1:0] blink_shadow_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      blink_shadow_reg <= '0;
    end else if (wrap) begin
      blink_shadow_reg <= i_blink_mask;
    end
  end

  assign blink_off = phase_reg && blink_shadow_reg[pos_reg];
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic unused_blink_mask;
  assign unused_blink_mask = ^i_blink_mask;
  assign blink_off = 1'b0;
`endif

  assign cur_nibble = values_shadow_reg[{pos_reg, 2'b00} +: 4];
  assign cur_blank  = lz_blank[pos_reg];
  assign cur_dp     = dp_shadow_reg[pos_reg];

  fnd_seg_decoder u_seg_decoder (
    .nibble (cur_nibble),
    .blank  (cur_blank || blink_off),
    .seg    (seg_next)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_an        <= '1;
      o_seg       <= SEG_BLANK;
      o_dp        <= 1'b1;
      o_digit_pos <= '0;
    end else begin
      o_an        <= an_next;
      o_seg       <= seg_next;
      o_dp        <= ~(cur_dp && !cur_blank && !blink_off);
      o_digit_pos <= pos_reg;
    end
  end

endmodule

// File: tb/tb_fnd_scan_mux.sv
// Scoreboard bench for fnd_scan_mux (DIGITS=4, TICK_DIV=4, BLINK_DIV=32); blink
// expectations follow FND_BLINK_EN.
module tb_fnd_scan_mux;

  localparam int DIGITS    = 4;
  localparam int TICK_DIV  = 4;
  localparam int BLINK_DIV = 32;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12, G7 = 7'h78, G8 = 7'h00, GA = 7'h08, GB = 7'h03;
  localparam logic [6:0] GC = 7'h46, GD = 7'h21, GE = 7'h06, BL = 7'h7F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] values = '0;
  logic [3:0]  dp_in = '0;
  logic        lz = 1'b0;
  logic [3:0]  mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out;
  logic [1:0]  pos;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] pos;
  } slot_t;

  slot_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    edge_n   = 0;

  always #5 clk = ~clk;

  fnd_scan_mux #(
    .DIGITS    (DIGITS),
    .TICK_DIV  (TICK_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_values     (values),
    .i_dp         (dp_in),
    .i_blank_lz   (lz),
    .i_blink_mask (mask),
    .o_an         (an),
    .o_seg        (seg),
    .o_dp         (dp_out),
    .o_digit_pos  (pos)
  );

  // Monitor: every new digit slot presented by the DUT is one transaction.
  logic [3:0] prev_an  = 'x;
  logic [1:0] prev_pos = 'x;
  slot_t      got;
  slot_t      want;

  always @(negedge clk) begin
    if ((an !== prev_an) || (pos !== prev_pos)) begin
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = '{an: an, seg: seg, dp: dp_out, pos: pos};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL slot: got an=%b seg=%h dp=%b pos=%0d, expected an=%b seg=%h dp=%b pos=%0d",
                   got.an, got.seg, got.dp, got.pos, want.an, want.seg, want.dp, want.pos);
        end else begin
          $display("slot ok: an=%b seg=%h dp=%b pos=%0d", got.an, got.seg, got.dp, got.pos);
        end
      end
    end
    prev_an  = an;
    prev_pos = pos;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("%s ok: %h", name, act);
    end
  endtask

  task automatic push_slot(input int p, input logic [6:0] s, input logic d);
    slot_t e;
    e.an      = 4'b1111;
    e.an[p]   = 1'b0;
    e.seg     = s;
    e.dp      = d;
    e.pos     = 2'(p);
    exp_q.push_back(e);
  endtask

  // dpn holds the expected active-low o_dp for digits 3..0.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpn);
    push_slot(0, s0, dpn[0]);
    push_slot(1, s1, dpn[1]);
    push_slot(2, s2, dpn[2]);
    push_slot(3, s3, dpn[3]);
  endtask

  // Called 2 time units after a posedge; returns 2 units after edge n since reset release.
  task automatic goto(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #2;
  endtask

  task automatic start_session(input logic [15:0] v, input logic [3:0] d,
                               input logic l, input logic [3:0] m);
    rst = 1'b1;
    values = v;
    dp_in  = d;
    lz     = l;
    mask   = m;
    #1;
    chk("reset_an",  16'(an),     16'h000F);
    chk("reset_seg", 16'(seg),    16'h007F);
    chk("reset_dp",  16'(dp_out), 16'h0001);
    chk("reset_pos", 16'(pos),    16'h0000);
    @(posedge clk);
    #2;
    rst    = 1'b0;
    edge_n = 0;
    push_frame(G0, G0, G0, G0, 4'hF);
  endtask

  initial begin
    @(posedge clk);
    #2;

    // Scan order and first capture
    start_session(16'h1234, 4'b0000, 1'b0, 4'b0000);
    goto(16);
    push_frame(G4, G3, G2, G1, 4'hF);
    goto(30);

    // Leading-zero blanking, dp suppressed on blanked digits, then all-zero value
    start_session(16'h0050, 4'b0110, 1'b1, 4'b0000);
    goto(16);
    push_frame(G0, G5, BL, BL, 4'b1101);
    goto(20);
    values = 16'h0000;
    goto(32);
    push_frame(G0, BL, BL, BL, 4'hF);
    goto(46);

    // Frame coherence: change lands while digit 2 is displayed
    start_session(16'h1111, 4'b0000, 1'b0, 4'b0000);
    goto(16);
    push_frame(G1, G1, G1, G1, 4'hF);
    goto(26);
    values = 16'h2222;
    goto(32);
    push_frame(G2, G2, G2, G2, 4'hF);
    goto(46);

    // Hex glyphs with dp, then an interior zero that must not be blanked
    start_session(16'hABCD, 4'b0100, 1'b1, 4'b0000);
    goto(16);
    push_frame(GD, GC, GB, GA, 4'b1011);
    goto(20);
    values = 16'h0E07;
    dp_in  = 4'b1000;
    goto(32);
    push_frame(G7, G0, GE, BL, 4'hF);
    goto(46);

    // Blink on digit 0: phase is high for outputs of frames 2 and 3
    start_session(16'h0008, 4'b0001, 1'b1, 4'b0001);
    for (int f = 1; f <= 4; f++) begin
      bit visible;
`ifdef FND_BLINK_EN
      visible = (f == 1) || (f == 4);
`else
      visible = 1'b1;
`endif
      goto(16 * f);
      push_frame(visible ? G8 : BL, BL, BL, BL, visible ? 4'b1110 : 4'b1111);
    end
    goto(78);

    // Asynchronous reset while digit 2 is driven, then scan restarts from digit 0
    start_session(16'h1234, 4'b0000, 1'b0, 4'b0000);
    goto(16);
    push_slot(0, G4, 1'b1);
    push_slot(1, G3, 1'b1);
    push_slot(2, G2, 1'b1);
    goto(26);
    start_session(16'h1234, 4'b0000, 1'b0, 4'b0000);
    goto(16);
    push_frame(G4, G3, G2, G1, 4'hF);
    goto(30);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
